// File: rtl/fifo_uart_tx.sv
// Drains bytes from an upstream FIFO and serialises them as UART frames (start, DATA_W bits LSB first, optional even parity, stop).
// Latency: read strobe one edge after a non-empty FIFO is seen in IDLE; start bit begins two edges after that.
// Backpressure: fetches only while idle with tx_en=1 and FIFO not empty; a frame already in flight always completes.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     baud_q, baud_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] shift_next;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              baud_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        rd_d       = 1'b0;
        busy_d     = busy_q;
        byte_done  = 1'b0;
        baud_end   = (baud_q == BAUD_LAST);
        shift_next = shift_q >> 1;

        // The baud counter only runs while a bit is on the line; it rests at zero otherwise.
        if (state_q inside {START, DATA, PARITY, STOP}) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_en && !fifo_empty) begin
                    rd_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d  = fifo_dout;
                parity_d = ^fifo_dout;
                tx_d     = 1'b0;
                state_d  = START;
            end
            START: begin
                if (baud_end) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_q == BIT_LAST) begin
                        if (PARITY_EN) begin
                            tx_d    = parity_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        shift_d = shift_next;
                        tx_d    = shift_next[0];
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                byte_done = baud_end;
                if (baud_end) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_rd = rd_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Two transmitters (no parity / even parity) fed by behavioural FIFOs; a line decoder pops expected bytes from a scoreboard.
module tb_fifo_uart_tx;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] tx_en = 2'b00;
    logic [1:0] fifo_empty, fifo_rd, tx, busy, byte_done;
    logic [7:0] fifo_dout [2] = '{8'h00, 8'h00};
    logic [1:0] wr_vld = 2'b00;
    logic [7:0] wr_dat [2] = '{8'h00, 8'h00};

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .tx_en(tx_en[0]), .fifo_empty(fifo_empty[0]), .fifo_dout(fifo_dout[0]),
        .fifo_rd(fifo_rd[0]), .tx(tx[0]), .busy(busy[0]), .byte_done(byte_done[0]));

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en[1]), .fifo_empty(fifo_empty[1]), .fifo_dout(fifo_dout[1]),
        .fifo_rd(fifo_rd[1]), .tx(tx[1]), .busy(busy[1]), .byte_done(byte_done[1]));

    // Upstream FIFO model: depth 8, dout registered on the edge that samples fifo_rd.
    logic [7:0] mem [2][8];
    int cnt [2] = '{0, 0};
    int wp  [2] = '{0, 0};
    int rp  [2] = '{0, 0};

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (fifo_rd[c] && cnt[c] > 0) begin
                fifo_dout[c] <= mem[c][rp[c]];
                rp[c]        <= (rp[c] + 1) % 8;
            end
            if (wr_vld[c] && cnt[c] < 8) begin
                mem[c][wp[c]] <= wr_dat[c];
                wp[c]         <= (wp[c] + 1) % 8;
            end
            cnt[c] <= cnt[c] - int'(fifo_rd[c] && cnt[c] > 0) + int'(wr_vld[c] && cnt[c] < 8);
        end
    end

    assign fifo_empty = {cnt[1] == 0, cnt[0] == 0};

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard and line-decoder state.
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    int gap_log [$];
    int cyc = 0;
    int rd_cyc   [2] = '{0, 0};
    int rd_cnt   [2] = '{0, 0};
    int frames   [2] = '{0, 0};
    int bd_cnt   [2] = '{0, 0};
    int last_end [2] = '{-1000, -1000};
    int m_pos    [2] = '{-1, -1};
    logic [11:0] m_bits [2];
    logic [1:0] m_unstable = 2'b00, m_busy_bad = 2'b00, m_bd_bad = 2'b00;
    logic [1:0] prev_empty = 2'b11, prev_rd = 2'b00, prev_en = 2'b00;

    task automatic mon_step(input int c);
        int nb, len, p, bi, gap;
        logic [7:0] b;
        logic [11:0] expb;
        nb  = (c == 1) ? 11 : 10;
        len = nb * CPB;
        if (!rst) begin
            m_pos[c]    = -1;
            last_end[c] = -1000;
            return;
        end
        if (fifo_rd[c]) begin
            // A read needs: no read last cycle, FIFO non-empty and tx_en high at the sampling edge.
            check("rd_legal", {29'd0, prev_rd[c], prev_empty[c], prev_en[c]}, 32'd1);
            rd_cyc[c] = cyc;
            rd_cnt[c]++;
        end
        if (byte_done[c]) bd_cnt[c]++;
        if (m_pos[c] < 0) begin
            if (tx[c] === 1'b0) begin
                check("start_latency", cyc - rd_cyc[c], 2);
                gap = cyc - last_end[c] - 1;
                check("min_gap", {31'd0, gap >= 3}, 1);
                if (c == 0) gap_log.push_back(gap);
                m_pos[c]      = 1;
                m_bits[c]     = '0;
                m_unstable[c] = 1'b0;
                m_busy_bad[c] = (busy[c] !== 1'b1);
                m_bd_bad[c]   = (byte_done[c] !== 1'b0);
            end
            return;
        end
        p  = m_pos[c];
        bi = p / CPB;
        if (p % CPB == 0) m_bits[c][bi] = tx[c];
        else if (tx[c] !== m_bits[c][bi]) m_unstable[c] = 1'b1;
        if (busy[c] !== 1'b1) m_busy_bad[c] = 1'b1;
        if (byte_done[c] !== (p == len - 1)) m_bd_bad[c] = 1'b1;
        if (p == len - 1) begin
            if ((c == 0 && exp0.size() == 0) || (c == 1 && exp1.size() == 0)) begin
                check("unexpected_frame", {20'd0, m_bits[c]}, 32'hFFFF_FFFF);
            end else begin
                b = (c == 0) ? exp0.pop_front() : exp1.pop_front();
                expb = (c == 1) ? {1'b0, 1'b1, ^b, b, 1'b0} : {2'b00, 1'b1, b, 1'b0};
                check("frame_bits", {20'd0, m_bits[c]}, {20'd0, expb});
                check("bit_stable", {31'd0, m_unstable[c]}, 0);
                check("busy_in_frame", {31'd0, m_busy_bad[c]}, 0);
                check("byte_done_pos", {31'd0, m_bd_bad[c]}, 0);
            end
            frames[c]++;
            last_end[c] = cyc;
            m_pos[c]    = -1;
        end else begin
            m_pos[c] = p + 1;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int c = 0; c < 2; c++) mon_step(c);
        prev_empty = fifo_empty;
        prev_rd    = fifo_rd;
        prev_en    = tx_en;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int c, input logic [7:0] b);
        wr_vld[c] = 1'b1;
        wr_dat[c] = b;
        if (c == 0) exp0.push_back(b);
        else exp1.push_back(b);
        tick();
        wr_vld[c] = 1'b0;
    endtask

    task automatic wait_drain(input int c, input int budget);
        int quiet;
        quiet = 0;
        for (int i = 0; i < budget && quiet < 3; i++) begin
            tick();
            if (cnt[c] == 0 && busy[c] == 1'b0 && fifo_rd[c] == 1'b0) quiet++;
            else quiet = 0;
        end
        check("drain_in_time", {31'd0, quiet >= 3}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r0, f0, b0;
        logic ok;
        repeat (3) tick();
        check("reset_tx", {30'd0, tx}, 32'd3);
        check("reset_fifo_rd", {30'd0, fifo_rd}, 0);
        check("reset_busy", {30'd0, busy}, 0);
        check("reset_byte_done", {30'd0, byte_done}, 0);
        rst = 1'b1;
        tick();

        // Single byte 0xA5.
        tx_en[0] = 1'b1;
        r0 = rd_cnt[0]; f0 = frames[0]; b0 = bd_cnt[0];
        push(0, 8'hA5);
        wait_drain(0, 200);
        check("a5_rd_pulses", rd_cnt[0] - r0, 1);
        check("a5_frames", frames[0] - f0, 1);
        check("a5_byte_done", bd_cnt[0] - b0, 1);

        // Empty FIFO with tx_en high.
        r0 = rd_cnt[0];
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || fifo_rd[0] !== 1'b0) ok = 1'b0;
        end
        check("empty_idle_line", {31'd0, ok}, 1);
        check("empty_no_rd", rd_cnt[0] - r0, 0);

        // Back-to-back bytes.
        gap_log.delete();
        r0 = rd_cnt[0]; f0 = frames[0];
        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        wait_drain(0, 400);
        check("b2b_rd_pulses", rd_cnt[0] - r0, 3);
        check("b2b_frames", frames[0] - f0, 3);
        check("b2b_gap1", (gap_log.size() > 1) ? gap_log[1] : -1, 3);
        check("b2b_gap2", (gap_log.size() > 2) ? gap_log[2] : -1, 3);

        // tx_en gating, including deassertion mid-frame.
        tx_en[0] = 1'b0;
        r0 = rd_cnt[0]; f0 = frames[0];
        push(0, 8'h5A);
        push(0, 8'hC3);
        repeat (20) tick();
        check("txen_low_no_rd", rd_cnt[0] - r0, 0);
        tx_en[0] = 1'b1;
        for (int i = 0; i < 10 && busy[0] !== 1'b1; i++) tick();
        check("txen_frame_started", {31'd0, busy[0]}, 1);
        repeat (6) tick();
        tx_en[0] = 1'b0;
        repeat (80) tick();
        check("txen_frame_completed", frames[0] - f0, 1);
        check("txen_single_rd", rd_cnt[0] - r0, 1);
        check("txen_byte_left", cnt[0], 1);
        tx_en[0] = 1'b1;
        wait_drain(0, 200);
        check("txen_resume_frames", frames[0] - f0, 2);

        // Asynchronous reset in the middle of a frame.
        f0 = frames[0];
        push(0, 8'h3C);
        push(0, 8'h81);
        for (int i = 0; i < 20 && tx[0] !== 1'b0; i++) tick();
        check("abort_frame_started", {31'd0, tx[0]}, 0);
        repeat (8) tick();
        rst = 1'b0;
        #1;
        check("abort_tx_high", {31'd0, tx[0]}, 1);
        check("abort_busy_low", {31'd0, busy[0]}, 0);
        check("abort_rd_low", {31'd0, fifo_rd[0]}, 0);
        check("abort_fifo_level", cnt[0], 1);
        void'(exp0.pop_front());
        repeat (3) tick();
        rst = 1'b1;
        wait_drain(0, 200);
        check("abort_resume_frames", frames[0] - f0, 1);

        // Even-parity instance: 0x07, then fill all 8 entries and drain.
        tx_en[1] = 1'b1;
        push(1, 8'h07);
        wait_drain(1, 300);
        check("par_frames", frames[1], 1);
        tx_en[1] = 1'b0;
        for (int i = 0; i < 8; i++) push(1, 8'($urandom));
        tick();
        check("par_fifo_full", cnt[1], 8);
        check("par_not_empty", {31'd0, fifo_empty[1]}, 0);
        tx_en[1] = 1'b1;
        wait_drain(1, 1000);
        check("par_fifo_empty", {31'd0, fifo_empty[1]}, 1);
        check("par_all_frames", frames[1], 9);
        check("par_all_rd", rd_cnt[1], 9);
        check("par_scoreboard_empty", exp1.size(), 0);

        // Random traffic with random tx_en toggling.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) tx_en[0] = 1'($urandom_range(0, 1));
            if (cnt[0] < 7 && $urandom_range(0, 24) == 0) push(0, 8'($urandom));
            else tick();
        end
        tx_en[0] = 1'b1;
        wait_drain(0, 3000);
        check("rand_scoreboard_empty", exp0.size(), 0);
        check("ch0_byte_done_count", bd_cnt[0], frames[0]);
        check("ch1_byte_done_count", bd_cnt[1], frames[1]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
